shift_add_mult_ctrl: RTL and testbench
======================================

Name: shift_add_mult_ctrl

Overview:
- Sequencing controller plus datapath registers for the 8x8 signed (two's-complement) shift-add multiplier.
- Owns the X/A/B registers and the iteration counter, and drives a single 9-bit add/subtract unit for 8 add/shift iterations.
- The final iteration subtracts (sign correction).
- Top level sees a start/busy/done handshake and a held 16-bit product.

Parameters:
- WIDTH, 8, operand width. The adder is WIDTH+1 bits; the product is 2*WIDTH bits.
- CNT_W, 3, iteration counter width, equal to $clog2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  level input; a multiply launches on its 0->1 transition while idle.
- multiplicand  input  WIDTH  operand S, signed; sampled at launch.
- multiplier  input  WIDTH  operand M, signed; sampled at launch.
- busy  output  1  high from the launch edge until done is asserted.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  signed result {A,B}; held until the next launch.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, and X, A, B, S_reg, cnt, busy, done, product, start_q all 0. Reset mid-operation aborts immediately. No result is produced, and start must toggle again after reset.
- Edge detect: start_q <= start every cycle. Launch = start & ~start_q & (state==IDLE).
  - A start rise while busy is ignored.
  - Start held high after completion does not relaunch.
- State IDLE:
  - On launch: A<=0, X<=0, B<=multiplier, S_reg<=multiplicand, cnt<=0, busy<=1, go to ADD.
- State ADD:
  - If B[0]=1: {X,A} <= 9-bit sum of sign-extended A and sign-extended S_reg. When cnt==WIDTH-1 this is a subtract, done as A + ~S + 1.
  - If B[0]=0: registers unchanged.
  - Go to SHIFT.
- State SHIFT:
  - Arithmetic right shift of {X,A,B}: A<={X,A[7:1]}, B<={A[0],B[7:1]}, X unchanged.
  - If cnt==WIDTH-1, go to DONE; otherwise cnt<=cnt+1 and go to ADD.
- State DONE:
  - product<={A,B}, done<=1 for exactly one cycle, busy<=0, go to IDLE.
- Latency:
  - For WIDTH=8, the launch edge is L. States are ADD/SHIFT across edges L+1..L+16, DONE is entered at L+16, and done/product are visible after edge L+17.
  - Fixed 17 cycles, independent of operand values.
- Arithmetic:
  - All adds are WIDTH+1 bits, and the carry out of the top bit is discarded.
  - The signed product always fits in 2*WIDTH bits, so there is no overflow flag.
  - -128*-128 = +16384 is representable.
- Operands changing after launch have no effect on the result.
- product is stable outside the DONE transition; busy and done are never high in the same cycle.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, ADD, SHIFT, DONE}.
  - WIDTH default constant.
  - Typedefs operand_t (logic signed [WIDTH-1:0]) and product_t (logic signed [2*WIDTH-1:0]).
- One sub-module, add_sub9: combinational (WIDTH+1)-bit adder/subtractor.
  - Inputs: a, b, sub.
  - Output: sum.
  - Instantiated once; the controller drives sub=(cnt==WIDTH-1).

Test Plan:
- Positive operands: S=7, M=5, start 0->1 -> busy high for 17 cycles, done pulses once, product=16'h0023.
- Negative multiplicand: S=-7 (8'hF9), M=5 -> product=16'hFFDD (-35).
- Negative multiplier (exercises the final subtract): S=5, M=-7 -> product=16'hFFDD. Also S=-128, M=-128 -> 16'h4000. Also S=8'h7F, M=8'h80 -> 16'hC080.
- Zero and identity: S=0, M=8'hA5 -> 16'h0000. S=1, M=-1 -> 16'hFFFF. Done is still exactly 17 cycles after launch.
- Handshake:
  - Start pulsed again at cycle 5 of a busy run -> ignored, and the original result is returned.
  - Start held high through DONE -> no second launch.
  - Operands changed mid-run -> no effect on the result.
- Reset mid-operation: assert rst_n=0 asynchronously at cycle 9 -> busy, done and product read 0 immediately. After release, a new start rise with S=3, M=3 -> product=16'h0009.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the signed shift-add multiplier controller.
package mult_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic signed [DEF_WIDTH-1:0]   operand_t;
    typedef logic signed [2*DEF_WIDTH-1:0] product_t;

endpackage

// File: rtl/add_sub9.sv
// Combinational adder/subtractor; subtract is formed as a + ~b + 1, carry out dropped.
module add_sub9
    import mult_pkg::*;
#(
    parameter int W = DEF_WIDTH + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] b_eff;
    logic [W-1:0] carry_in;

    always_comb begin
        b_eff    = sub ? ~b : b;
        carry_in = {{(W-1){1'b0}}, sub};
        sum      = a + b_eff + carry_in;
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequencer and datapath registers for the signed shift-add multiplier.
//   state | meaning
//   IDLE  | waiting for a start rise; product holds the last result
//   ADD   | conditionally add (or, on the last pass, subtract) S into {X,A}
//   SHIFT | arithmetic right shift of {X,A,B}; advance or finish
//   DONE  | publish {A,B}, pulse done, drop busy
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    logic               start_q;
    logic               x_bit;
    logic [WIDTH-1:0]   a_hi;
    logic [WIDTH-1:0]   b_lo;
    logic [WIDTH-1:0]   s_reg;
    logic [CNT_W-1:0]   cnt;

    logic               last_iter;
    logic               launch;
    logic [WIDTH:0]     sum;

    // The last partial product carries negative weight, hence the subtract.
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign launch    = start & ~start_q & (state == IDLE);

    add_sub9 #(
        .W   (WIDTH + 1)
    ) u_add_sub (
        .a   ({a_hi[WIDTH-1], a_hi}),
        .b   ({s_reg[WIDTH-1], s_reg}),
        .sub (last_iter),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            start_q <= 1'b0;
            x_bit   <= 1'b0;
            a_hi    <= '0;
            b_lo    <= '0;
            s_reg   <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            start_q <= start;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        x_bit <= 1'b0;
                        a_hi  <= '0;
                        b_lo  <= multiplier;
                        s_reg <= multiplicand;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (b_lo[0]) begin
                        {x_bit, a_hi} <= sum;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    a_hi <= {x_bit, a_hi[WIDTH-1:1]};
                    b_lo <= {a_hi[0], b_lo[WIDTH-1:1]};
                    if (last_iter) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        state <= ADD;
                    end
                end
                DONE: begin
                    product <= {a_hi, b_lo};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl: expected products queued at launch, checked on done.
module tb_shift_add_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] prod;
        int          launch;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] last_prod = '0;

    shift_add_mult_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("product", 32'(product), 32'(e.prod));
                    check("latency", 32'(cyc - e.launch), 32'd17);
                end
                check("busy_with_done", 32'(busy), 32'd0);
            end else if (product !== last_prod) begin
                check("product_hold", 32'(product), 32'(last_prod));
            end
        end
        last_prod = product;
    end

    task automatic do_mult(input logic [7:0] s, input logic [7:0] m, input logic [15:0] expv,
                           input bit hold, input bit repulse, input bit chg);
        exp_t e;
        int   nbusy;
        bit   seen;
        @(posedge clk);
        #1;
        multiplicand = s;
        multiplier   = m;
        start        = 1'b1;
        e.prod   = expv;
        e.launch = cyc + 1;
        sb.push_back(e);
        nbusy = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            if (!hold && !repulse) start = 1'b0;
            if (repulse && k == 2) start = 1'b0;
            if (repulse && k == 4) start = 1'b1;
            if (chg) begin
                multiplicand = 8'($urandom);
                multiplier   = 8'($urandom);
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("busy_cycles", 32'(nbusy), 32'd17);
        if (hold || repulse) begin
            repeat (6) begin
                @(posedge clk);
                #1;
            end
            check("no_relaunch", 32'(busy), 32'd0);
        end
        start = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    logic signed [7:0]  rs;
    logic signed [7:0]  rm;
    logic signed [15:0] rp;

    initial begin
        #200_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        do_mult(8'd7,   8'd5,   16'h0023, 0, 0, 0);
        do_mult(8'hF9,  8'd5,   16'hFFDD, 0, 0, 0);
        do_mult(8'd5,   8'hF9,  16'hFFDD, 0, 0, 0);
        do_mult(8'h80,  8'h80,  16'h4000, 0, 0, 0);
        do_mult(8'h7F,  8'h80,  16'hC080, 0, 0, 0);
        do_mult(8'h00,  8'hA5,  16'h0000, 0, 0, 0);
        do_mult(8'h01,  8'hFF,  16'hFFFF, 0, 0, 0);
        do_mult(8'd13,  8'hF3,  16'hFF57, 0, 1, 0);
        do_mult(8'hC4,  8'd9,   16'hFDE4, 1, 0, 0);
        do_mult(8'd100, 8'hE7,  16'hF63C, 0, 0, 1);

        for (int i = 0; i < 4; i++) begin
            rs = 8'($urandom);
            rm = 8'($urandom);
            rp = rs * rm;
            do_mult(rs, rm, rp, 0, 0, i[0]);
        end

        // Abort mid-run with an asynchronous reset.
        @(posedge clk);
        #1;
        multiplicand = 8'd77;
        multiplier   = 8'd33;
        start        = 1'b1;
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_product", 32'(product), 32'd0);
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        check("abort_idle", 32'(busy), 32'd0);
        do_mult(8'd3, 8'd3, 16'h0009, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
